uart_rx_frame_assembler: RTL and testbench

UART_RX_FRAME_ASSEMBLER -- requirements
Module: uart_rx_frame_assembler

---
 rtl/uart_rx_frame_assembler.sv | 151 +++++++++++++++
 tb/tb_uart_rx_frame_assembler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_assembler.sv
// UART receive frame assembler: collects mid-bit samples into a parallel word.
// Optional parity stage is built when UART_RX_PARITY_EN is defined.
module uart_rx_frame_assembler #(
    parameter int DATA_WIDTH = 8,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              bit_valid,
    input  logic                              sampled_bit,
`ifdef UART_RX_PARITY_EN
    input  logic                              parity_odd,
`endif
    input  logic                              data_ack,
    output logic [DATA_WIDTH-1:0]             parallel_data,
    output logic                              data_valid,
    output logic                              busy,
    output logic [$clog2(DATA_WIDTH+1)-1:0]   bit_count,
`ifdef UART_RX_PARITY_EN
    output logic                              parity_error,
`endif
    output logic                              overrun
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_PARITY
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [CW-1:0]         pos;
    logic                  capture;
    logic                  last_bit;
    logic                  complete;

    // start always wins over a coincident data strobe
    assign capture  = (state_q == S_SHIFT) && bit_valid && !start;
    assign last_bit = capture && (bit_count == LAST);

`ifdef UART_RX_PARITY_EN
    assign complete = (state_q == S_PARITY) && bit_valid && !start;
`else
    assign complete = last_bit;
`endif

    assign pos = LSB_FIRST ? bit_count : (LAST - bit_count);

    // merge the incoming bit so the final data bit reaches the word same edge
    always_comb begin
        shift_d = shift_q;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (capture && (pos == CW'(i))) begin
                shift_d[i] = sampled_bit;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (start) begin
                    state_d = S_SHIFT;
                end else if (last_bit) begin
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            S_PARITY: begin
                if (start) begin
                    state_d = S_SHIFT;
                end else if (bit_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_SHIFT) || (state_q == S_PARITY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q   <= '0;
            bit_count <= '0;
        end else if (start) begin
            shift_q   <= '0;
            bit_count <= '0;
        end else if (complete) begin
            shift_q   <= shift_d;
            bit_count <= '0;
        end else if (capture) begin
            shift_q   <= shift_d;
            bit_count <= bit_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parallel_data <= '0;
            data_valid    <= 1'b0;
            overrun       <= 1'b0;
        end else if (complete) begin
            parallel_data <= shift_d;
            data_valid    <= 1'b1;
            if (data_valid && !data_ack) begin
                overrun <= 1'b1;
            end
        end else if (data_ack && data_valid) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_error <= 1'b0;
        end else if (complete) begin
            parity_error <= (^shift_d) ^ sampled_bit ^ parity_odd;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// Directed bench for uart_rx_frame_assembler, LSB-first and MSB-first builds.
// Parity checks are compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_rx_frame_assembler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       bit_valid = 1'b0;
    logic       sampled_bit = 1'b0;
    logic       data_ack = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic       parity_odd = 1'b0;
    logic       pe_a;
    logic       pe_b;
`endif
    logic [7:0] pd_a;
    logic [7:0] pd_b;
    logic       dv_a;
    logic       dv_b;
    logic       busy_a;
    logic       busy_b;
    logic [3:0] bc_a;
    logic [3:0] bc_b;
    logic       ov_a;
    logic       ov_b;

    int errors = 0;
    int checks = 0;
    int dv_rises = 0;

    always #5 clk = ~clk;

    always @(posedge dv_a) dv_rises++;

    uart_rx_frame_assembler #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) u_a (
        .clk(clk),
        .reset(reset),
        .start(start),
        .bit_valid(bit_valid),
        .sampled_bit(sampled_bit),
`ifdef UART_RX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .data_ack(data_ack),
        .parallel_data(pd_a),
        .data_valid(dv_a),
        .busy(busy_a),
        .bit_count(bc_a),
`ifdef UART_RX_PARITY_EN
        .parity_error(pe_a),
`endif
        .overrun(ov_a)
    );

    uart_rx_frame_assembler #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) u_b (
        .clk(clk),
        .reset(reset),
        .start(start),
        .bit_valid(bit_valid),
        .sampled_bit(sampled_bit),
`ifdef UART_RX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .data_ack(data_ack),
        .parallel_data(pd_b),
        .data_valid(dv_b),
        .busy(busy_b),
        .bit_count(bc_b),
`ifdef UART_RX_PARITY_EN
        .parity_error(pe_b),
`endif
        .overrun(ov_b)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_valid   = 1'b1;
        sampled_bit = b;
        tick();
        bit_valid   = 1'b0;
    endtask

    // bits are sent in list order, first element first
    task automatic send_bits(input logic [7:0] seq, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(seq[7-i]);
        end
    endtask

    task automatic ack();
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_pd", pd_a, 8'h00);
        check("rst_dv", dv_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_bc", bc_a, 4'd0);
        check("rst_ov", ov_a, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        send_bit(1'b1);
        check("idle_bv_busy", busy_a, 1'b0);
        check("idle_bv_bc", bc_a, 4'd0);

        pulse_start();
        check("start_busy", busy_a, 1'b1);
        check("start_bc", bc_a, 4'd0);
        send_bits(8'b1010_0100, 7);
        check("a5_bc7", bc_a, 4'd7);
        check("a5_dv_early", dv_a, 1'b0);
        send_bit(1'b1);
        check("a5_dv", dv_a, 1'b1);
        check("a5_pd_lsb", pd_a, 8'hA5);
        check("a5_pd_msb", pd_b, 8'hA5);
        check("a5_busy", busy_a, 1'b0);
        check("a5_bc0", bc_a, 4'd0);
        ack();
        check("ack_dv", dv_a, 1'b0);

        pulse_start();
        send_bits(8'b1100_0000, 8);
        check("c0_pd_lsb", pd_a, 8'h03);
        check("c0_pd_msb", pd_b, 8'hC0);
        ack();

        pulse_start();
        send_bits(8'b1000_1000, 8);
        check("f11_pd", pd_a, 8'h11);
        check("f11_ov", ov_a, 1'b0);
        pulse_start();
        send_bits(8'b0100_0100, 8);
        check("f22_pd", pd_a, 8'h22);
        check("f22_dv", dv_a, 1'b1);
        check("f22_ov", ov_a, 1'b1);
        ack();
        check("ovack_dv", dv_a, 1'b0);
        check("ovack_ov", ov_a, 1'b0);

        dv_rises = 0;
        pulse_start();
        send_bits(8'b1110_0000, 3);
        check("part_bc3", bc_a, 4'd3);
        pulse_start();
        check("restart_bc", bc_a, 4'd0);
        check("restart_dv", dv_a, 1'b0);
        send_bits(8'b0011_1100, 8);
        check("f3c_pd", pd_a, 8'h3C);
        check("f3c_rises", dv_rises, 1);
        ack();

        pulse_start();
        send_bits(8'b1010_1010, 8);
        check("f55_pd", pd_a, 8'h55);
        pulse_start();
        send_bits(8'b1111_0000, 7);
        data_ack = 1'b1;
        send_bit(1'b0);
        data_ack = 1'b0;
        check("sim_pd", pd_a, 8'h0F);
        check("sim_dv", dv_a, 1'b1);
        check("sim_ov", ov_a, 1'b0);

        start = 1'b1;
        bit_valid = 1'b1;
        sampled_bit = 1'b1;
        tick();
        start = 1'b0;
        bit_valid = 1'b0;
        check("sb_bc", bc_a, 4'd0);
        check("sb_busy", busy_a, 1'b1);
        send_bits(8'b1111_0000, 4);
        check("mid_bc4", bc_a, 4'd4);
        #2;
        reset = 1'b0;
        #1;
        check("arst_pd", pd_a, 8'h00);
        check("arst_dv", dv_a, 1'b0);
        check("arst_busy", busy_a, 1'b0);
        check("arst_bc", bc_a, 4'd0);
        @(negedge clk);
        reset = 1'b1;
        send_bits(8'b1111_1111, 8);
        check("nostart_bc", bc_a, 4'd0);
        check("nostart_busy", busy_a, 1'b0);
        check("nostart_dv", dv_a, 1'b0);

`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        pulse_start();
        send_bits(8'b1100_0000, 8);
        check("par_bc8", bc_a, 4'd8);
        check("par_busy", busy_a, 1'b1);
        check("par_dv_early", dv_a, 1'b0);
        send_bit(1'b1);
        check("par_pd", pd_a, 8'h03);
        check("par_dv", dv_a, 1'b1);
        check("par_err1", pe_a, 1'b1);
        ack();
        pulse_start();
        send_bits(8'b1100_0000, 8);
        send_bit(1'b0);
        check("par_err0", pe_a, 1'b0);
        ack();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
